// File: rtl/kbd_pkg.sv
// rtl/kbd_pkg.sv - scan codes, digit lookup and FSM state types for the PS/2 keyboard
package kbd_pkg;

  localparam logic [7:0] SC_E0    = 8'hE0;
  localparam logic [7:0] SC_F0    = 8'hF0;
  localparam logic [7:0] SC_ENTER = 8'h5A;
  localparam logic [7:0] SC_BKSP  = 8'h66;
  localparam logic [7:0] SC_LEFT  = 8'h6B;
  localparam logic [7:0] SC_RIGHT = 8'h74;
  localparam logic [7:0] SC_DEL   = 8'h71;

  localparam logic [7:0] SC_D0 = 8'h45;
  localparam logic [7:0] SC_D1 = 8'h16;
  localparam logic [7:0] SC_D2 = 8'h1E;
  localparam logic [7:0] SC_D3 = 8'h26;
  localparam logic [7:0] SC_D4 = 8'h25;
  localparam logic [7:0] SC_D5 = 8'h2E;
  localparam logic [7:0] SC_D6 = 8'h36;
  localparam logic [7:0] SC_D7 = 8'h3D;
  localparam logic [7:0] SC_D8 = 8'h3E;
  localparam logic [7:0] SC_D9 = 8'h46;

  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} rx_state_t;
  typedef enum logic [1:0] {NORM, EXT, BRK, EXT_BRK} dec_state_t;

  // Returns {hit, ascii}; hit is 0 for anything that is not a digit key.
  function automatic logic [8:0] digit_ascii(input logic [7:0] code);
    logic [8:0] r;
    r = 9'd0;
    case (code)
      SC_D0:   r = {1'b1, 8'h30};
      SC_D1:   r = {1'b1, 8'h31};
      SC_D2:   r = {1'b1, 8'h32};
      SC_D3:   r = {1'b1, 8'h33};
      SC_D4:   r = {1'b1, 8'h34};
      SC_D5:   r = {1'b1, 8'h35};
      SC_D6:   r = {1'b1, 8'h36};
      SC_D7:   r = {1'b1, 8'h37};
      SC_D8:   r = {1'b1, 8'h38};
      SC_D9:   r = {1'b1, 8'h39};
      default: r = 9'd0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/ps2_rx.sv
// rtl/ps2_rx.sv - PS/2 frame receiver: sync, edge detect, framing FSM, timeout
// Odd-parity checking is compiled in only when PS2_PARITY_CHECK_EN is defined.
module ps2_rx #(
  parameter int TIMEOUT_CYC = 5000
) (
  input  logic       clk,
  input  logic       Reset,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [7:0] byte_out,
  output logic       byte_valid,
  output logic       frame_err
);
  import kbd_pkg::*;

  localparam int CW = $clog2(TIMEOUT_CYC + 1);

  logic [2:0]  clk_sync;
  logic [1:0]  data_sync;
  logic        fall;
  logic        bit_in;
  logic        timeout;
  rx_state_t   state;
  rx_state_t   state_d;
  logic [7:0]  shift;
  logic [2:0]  bit_cnt;
  logic        parity_ok;
  logic [CW-1:0] idle_cnt;

  assign fall    = clk_sync[2] & ~clk_sync[1];
  assign bit_in  = data_sync[1];
  // A real edge in the same cycle wins over an expiring timeout.
  assign timeout = (state != IDLE) && !fall && (idle_cnt == CW'(TIMEOUT_CYC));

  always_comb begin
    state_d = state;
    if (timeout) begin
      state_d = IDLE;
    end else if (fall) begin
      case (state)
        IDLE:    if (!bit_in) state_d = DATA;
        DATA:    if (bit_cnt == 3'd7) state_d = PARITY;
        PARITY:  state_d = STOP;
        STOP:    state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (Reset) begin
      clk_sync   <= '0;
      data_sync  <= '0;
      state      <= IDLE;
      shift      <= '0;
      bit_cnt    <= '0;
      parity_ok  <= 1'b0;
      idle_cnt   <= '0;
      byte_out   <= '0;
      byte_valid <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      clk_sync   <= {clk_sync[1:0], ps2_clk};
      data_sync  <= {data_sync[0], ps2_data};
      state      <= state_d;
      byte_valid <= 1'b0;
      frame_err  <= 1'b0;

      if (fall || timeout || state == IDLE)
        idle_cnt <= '0;
      else
        idle_cnt <= idle_cnt + CW'(1);

      if (fall) begin
        case (state)
          IDLE: bit_cnt <= '0;
          DATA: begin
            shift   <= {bit_in, shift[7:1]};
            bit_cnt <= bit_cnt + 3'd1;
          end
          PARITY: begin
`ifdef PS2_PARITY_CHECK_EN
            parity_ok <= ^{shift, bit_in};
`else
            parity_ok <= 1'b1;
`endif
          end
          STOP: begin
            if (bit_in && parity_ok) begin
              byte_out   <= shift;
              byte_valid <= 1'b1;
            end else begin
              frame_err  <= 1'b1;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: rtl/ps2_keyboard.sv
// rtl/ps2_keyboard.sv - PS/2 keyboard front-end: scan-code decoder to digit/edit pulses
// Parity checking in ps2_rx is enabled by defining PS2_PARITY_CHECK_EN.
module ps2_keyboard #(
  parameter int TIMEOUT_CYC = 5000
) (
  input  logic       clk,
  input  logic       Reset,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [7:0] char_out,
  output logic       char_valid,
  output logic       left_cursor,
  output logic       right_cursor,
  output logic       Delete,
  output logic       Enter,
  output logic       frame_err
);
  import kbd_pkg::*;

  logic [7:0] rx_byte;
  logic       rx_valid;
  logic       rx_err;

  ps2_rx #(.TIMEOUT_CYC(TIMEOUT_CYC)) u_rx (
    .clk        (clk),
    .Reset      (Reset),
    .ps2_clk    (ps2_clk),
    .ps2_data   (ps2_data),
    .byte_out   (rx_byte),
    .byte_valid (rx_valid),
    .frame_err  (rx_err)
  );

  assign frame_err = rx_err;

  dec_state_t dec;
  dec_state_t dec_d;
  logic [8:0] digit;
  logic       char_hit;
  logic       left_hit;
  logic       right_hit;
  logic       del_hit;
  logic       enter_hit;

  always_comb begin
    dec_d     = dec;
    digit     = digit_ascii(rx_byte);
    char_hit  = 1'b0;
    left_hit  = 1'b0;
    right_hit = 1'b0;
    del_hit   = 1'b0;
    enter_hit = 1'b0;
    if (rx_valid) begin
      if (rx_byte == SC_E0) begin
        dec_d = EXT;
      end else if (rx_byte == SC_F0) begin
        dec_d = (dec == EXT || dec == EXT_BRK) ? EXT_BRK : BRK;
      end else begin
        // Every non-prefix byte ends the sequence; break codes produce nothing.
        dec_d = NORM;
        case (dec)
          NORM: begin
            char_hit  = digit[8];
            enter_hit = (rx_byte == SC_ENTER);
            del_hit   = (rx_byte == SC_BKSP);
          end
          EXT: begin
            left_hit  = (rx_byte == SC_LEFT);
            right_hit = (rx_byte == SC_RIGHT);
            del_hit   = (rx_byte == SC_DEL);
          end
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (Reset) begin
      dec          <= NORM;
      char_out     <= '0;
      char_valid   <= 1'b0;
      left_cursor  <= 1'b0;
      right_cursor <= 1'b0;
      Delete       <= 1'b0;
      Enter        <= 1'b0;
    end else begin
      dec          <= dec_d;
      char_valid   <= char_hit;
      left_cursor  <= left_hit;
      right_cursor <= right_hit;
      Delete       <= del_hit;
      Enter        <= enter_hit;
      if (char_hit) char_out <= digit[7:0];
    end
  end

endmodule

// File: tb/tb_ps2_keyboard.sv
// tb/tb_ps2_keyboard.sv - scoreboard bench for ps2_keyboard
module tb_ps2_keyboard;

  localparam int TO   = 200;
  localparam int HALF = 6;

  localparam logic [3:0] EV_CHAR  = 4'd1;
  localparam logic [3:0] EV_LEFT  = 4'd2;
  localparam logic [3:0] EV_RIGHT = 4'd3;
  localparam logic [3:0] EV_DEL   = 4'd4;
  localparam logic [3:0] EV_ENTER = 4'd5;
  localparam logic [3:0] EV_ERR   = 4'd6;

  logic       clk = 1'b0;
  logic       Reset = 1'b1;
  logic       ps2_clk = 1'b1;
  logic       ps2_data = 1'b1;
  logic [7:0] char_out;
  logic       char_valid;
  logic       left_cursor;
  logic       right_cursor;
  logic       Delete;
  logic       Enter;
  logic       frame_err;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int stop_cyc = 0;
  int last_evt_cyc = 0;
  int mon_n;
  logic [11:0] mon_obs;
  logic [11:0] sb[$];

  ps2_keyboard #(.TIMEOUT_CYC(TO)) dut (
    .clk          (clk),
    .Reset        (Reset),
    .ps2_clk      (ps2_clk),
    .ps2_data     (ps2_data),
    .char_out     (char_out),
    .char_valid   (char_valid),
    .left_cursor  (left_cursor),
    .right_cursor (right_cursor),
    .Delete       (Delete),
    .Enter        (Enter),
    .frame_err    (frame_err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!Reset) begin
      mon_n = int'(char_valid) + int'(left_cursor) + int'(right_cursor)
            + int'(Delete) + int'(Enter) + int'(frame_err);
      if (char_valid)        mon_obs = {EV_CHAR, char_out};
      else if (left_cursor)  mon_obs = {EV_LEFT, 8'h00};
      else if (right_cursor) mon_obs = {EV_RIGHT, 8'h00};
      else if (Delete)       mon_obs = {EV_DEL, 8'h00};
      else if (Enter)        mon_obs = {EV_ENTER, 8'h00};
      else                   mon_obs = {EV_ERR, 8'h00};
      if (mon_n > 1) begin
        check("one_pulse_per_cycle", mon_n, 1);
      end else if (mon_n == 1) begin
        if (sb.size() == 0) begin
          check("unexpected_pulse", {20'd0, mon_obs}, 32'd0);
        end else begin
          check("event", {20'd0, mon_obs}, {20'd0, sb.pop_front()});
          last_evt_cyc = cyc;
        end
      end
    end
  end

  function automatic logic [10:0] frame(input logic [7:0] b, input logic flip, input logic stop);
    return {stop, (~^b) ^ flip, b, 1'b0};
  endfunction

  task automatic put_bit(input logic b, input logic is_stop);
    @(negedge clk);
    ps2_data = b;
    repeat (HALF) @(negedge clk);
    ps2_clk = 1'b0;
    if (is_stop) stop_cyc = cyc;
    repeat (HALF) @(negedge clk);
    ps2_clk = 1'b1;
  endtask

  task automatic send_bits(input logic [10:0] f, input int lo, input int hi);
    for (int i = lo; i <= hi; i++) put_bit(f[i], i == 10);
    ps2_data = 1'b1;
    repeat (2 * HALF) @(negedge clk);
  endtask

  task automatic send(input logic [7:0] b);
    send_bits(frame(b, 1'b0, 1'b1), 0, 10);
  endtask

  task automatic expect_ev(input logic [3:0] t, input logic [7:0] c);
    sb.push_back({t, c});
  endtask

  task automatic drain(input string tag);
    repeat (20) @(negedge clk);
    check(tag, sb.size(), 0);
  endtask

  initial begin
    repeat (4) @(negedge clk);
    check("rst_char_out", char_out, 8'h00);
    check("rst_pulses", {char_valid, left_cursor, right_cursor, Delete, Enter, frame_err}, 6'd0);
    Reset = 1'b0;
    repeat (10) @(negedge clk);

    expect_ev(EV_CHAR, 8'h31);
    send(8'h16);
    drain("sb_digit1");
    check("latency_stop_to_pulse", last_evt_cyc - stop_cyc, 4);
    check("char_out_held", char_out, 8'h31);

    expect_ev(EV_LEFT, 8'h00);
    send(8'hE0); send(8'h6B);
    send(8'hE0); send(8'hF0); send(8'h6B);
    drain("sb_left_and_break");

    expect_ev(EV_ENTER, 8'h00);
    send(8'h5A); send(8'hF0); send(8'h5A);
    expect_ev(EV_DEL, 8'h00);
    send(8'h66);
    drain("sb_enter_bksp");

    expect_ev(EV_RIGHT, 8'h00);
    send(8'hE0); send(8'h74);
    expect_ev(EV_DEL, 8'h00);
    send(8'hE0); send(8'h71);
    send(8'h1C);
    expect_ev(EV_CHAR, 8'h33);
    send(8'h26);
    expect_ev(EV_CHAR, 8'h39);
    expect_ev(EV_CHAR, 8'h39);
    send(8'h46); send(8'h46);
    drain("sb_ext_unlisted_typematic");

`ifdef PS2_PARITY_CHECK_EN
    expect_ev(EV_ERR, 8'h00);
`else
    expect_ev(EV_CHAR, 8'h32);
`endif
    send_bits(frame(8'h1E, 1'b1, 1'b1), 0, 10);
    drain("sb_parity_flip");

    expect_ev(EV_ERR, 8'h00);
    send_bits(frame(8'h16, 1'b0, 1'b0), 0, 10);
    drain("sb_bad_stop");

    send_bits(frame(8'h45, 1'b0, 1'b1), 0, 4);
    repeat (TO + 10) @(negedge clk);
    expect_ev(EV_CHAR, 8'h30);
    send(8'h45);
    drain("sb_timeout_recover");

    send(8'hE0);
    send_bits(frame(8'h6B, 1'b0, 1'b1), 0, 4);
    @(negedge clk);
    Reset = 1'b1;
    @(negedge clk);
    check("midrst_char_out", char_out, 8'h00);
    check("midrst_pulses", {char_valid, left_cursor, right_cursor, Delete, Enter, frame_err}, 6'd0);
    Reset = 1'b0;
    send_bits(frame(8'h6B, 1'b0, 1'b1), 5, 10);
    repeat (TO + 20) @(negedge clk);
    send(8'h6B);
    drain("sb_after_reset_no_left");
    expect_ev(EV_CHAR, 8'h31);
    send(8'h16);
    drain("sb_after_reset_norm");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ps2_keyboard.md
# ps2_keyboard

PS/2 keyboard front-end feeding the text-entry path. It deserializes PS/2 device-to-host frames and decodes make/break/extended scan-code sequences. It emits a one-cycle ASCII digit strobe plus one-cycle cursor-left, cursor-right, delete and enter pulses, which drive the character input, the receive strobe and the four edit controls of the existing display/editing logic.

## Interface
- `TIMEOUT_CYC`, default 5000: idle `clk` cycles between PS/2 falling edges after which a partial frame is discarded.
- `clk` input 1: system clock; all logic on the rising edge.
- `Reset` input 1: synchronous, active-high; clears every register.
- `ps2_clk` input 1: raw PS/2 clock, asynchronous.
- `ps2_data` input 1: raw PS/2 data, asynchronous.
- `char_out` output 8: ASCII code `0x30`–`0x39`; held until the next `char_valid`; reset `0x00`.
- `char_valid` output 1: one-cycle strobe, `char_out` is new; reset 0.
- `left_cursor` output 1: one-cycle pulse; reset 0.
- `right_cursor` output 1: one-cycle pulse; reset 0.
- `Delete` output 1: one-cycle pulse; reset 0.
- `Enter` output 1: one-cycle pulse; reset 0.
- `frame_err` output 1: one-cycle pulse on a dropped frame; reset 0.

## Operation
- Input conditioning:
  - `ps2_clk` and `ps2_data` each pass through a 2-flop synchronizer.
  - A third flop on `ps2_clk` detects the falling edge.
  - Data is sampled only in the cycle the synchronized falling edge is detected.
- Receiver FSM (`IDLE`, `DATA`, `PARITY`, `STOP`):
  - `IDLE`: a sampled 0 moves to `DATA`; a sampled 1 stays in `IDLE`.
  - `DATA`: shifts 8 bits, LSB first, with a 3-bit counter, then moves to `PARITY`.
  - `PARITY`: captures the parity bit, then moves to `STOP`.
  - `STOP`: the stop bit must be 1 and parity must pass. On success the byte is issued; otherwise `frame_err` pulses. Either way the FSM returns to `IDLE`.
- Timeout:
  - An idle counter resets on every falling edge.
  - When it reaches `TIMEOUT_CYC` in any state other than `IDLE`, the FSM returns to `IDLE` with no byte and no `frame_err`.
- Decoder FSM (`NORM`, `EXT`, `BRK`, `EXT_BRK`):
  - `0xE0`: `NORM`→`EXT`.
  - `0xF0`: `NORM`→`BRK`, `EXT`→`EXT_BRK`.
  - Any other byte in `BRK` or `EXT_BRK` is a break code: no output, return to `NORM`.
  - Make codes in `NORM` produce these outputs:
    - `0x45` `0x16` `0x1E` `0x26` `0x25` `0x2E` `0x36` `0x3D` `0x3E` `0x46` give `char_out` = ASCII `'0'`–`'9'` with `char_valid`.
    - `0x5A` gives `Enter`.
    - `0x66` (Backspace) gives `Delete`.
  - Make codes in `EXT` produce these outputs, then return to `NORM`:
    - `0x6B` gives `left_cursor`.
    - `0x74` gives `right_cursor`.
    - `0x71` gives `Delete`.
  - Unlisted make codes are ignored and leave the decoder in `NORM`.
- At most one output pulse is asserted in any cycle.
- Typematic repeats (the same make code again) each produce a new pulse.
- `0xE0` or `0xF0` received while already in a prefix state: the decoder stays in or advances to the corresponding prefix state (`EXT`+`0xE0`→`EXT`; `BRK`+`0xE0`→`EXT`); no output.

## Timing
- Cycle N: the falling edge that samples the stop bit is detected.
- Cycle N+1: internal byte strobe, or `frame_err` high.
- Cycle N+2: decoded output pulse high for exactly one cycle.
- The input synchronizer adds 2 cycles before edge detection.
- `Reset` asserted mid-frame or between prefix and code:
  - Both FSMs return to `IDLE`/`NORM` and the counters clear.
  - All outputs are 0 in the cycle after `Reset` is sampled high.
  - Remaining bits of an interrupted frame are discarded by the start-bit check or by the timeout.
- `Reset` has priority over every event.

## Configuration
- `PS2_PARITY_CHECK_EN` defined:
  - Odd parity over the 8 data bits plus the parity bit is checked.
  - On mismatch the byte is dropped and `frame_err` pulses.
- Not defined:
  - The parity bit is sampled and ignored.
  - `frame_err` reports only a bad stop bit.

## Structure
- Shared package `kbd_pkg`:
  - Scan-code localparams (`SC_E0`, `SC_F0`, `SC_ENTER`, `SC_BKSP`, `SC_LEFT`, `SC_RIGHT`, `SC_DEL`, digit codes).
  - Enum typedefs for the receiver and decoder states.
- Sub-module `ps2_rx`: synchronizer, edge detect, receiver FSM, timeout and parity. Outputs are `byte_out[7:0]`, `byte_valid` and `frame_err`.
- `ps2_keyboard` instantiates `ps2_rx` and contains the decoder FSM and the output registers.

## Test plan
- Frame `0x16` with correct parity → `char_out`=`0x31`, `char_valid` high 1 cycle, N+2 after the stop-bit edge.
- Sequence `0xE0`,`0x6B`, then `0xE0`,`0xF0`,`0x6B` → exactly one `left_cursor` pulse; the break produces nothing.
- `0x5A` then `0xF0`,`0x5A` → one `Enter` pulse; `0x66` → one `Delete` pulse.
- Frame `0x1E` with the parity bit flipped:
  - With `PS2_PARITY_CHECK_EN`: `frame_err` pulse and no `char_valid`.
  - Without it: `char_out`=`0x32` with `char_valid`.
- Stop bit 0 → `frame_err` pulse; 5 bits then silence for `TIMEOUT_CYC`+1 cycles → no output, and a following valid `0x45` frame gives `char_out`=`0x30`.
- `Reset` pulsed after `0xE0` and mid-way through the next frame, then a clean `0x6B` frame → no `left_cursor`, no `char_valid`, and the decoder is in `NORM`.
